// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SD-card SPI command sequencer with R1 response polling.
// Drives an external byte shifter and detects byte boundaries from its bit index.
module spi_cmd_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int NCR_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  cmd_idx,
   input  logic [31:0] cmd_arg,
   input  logic [6:0]  crc7,
   output logic        busy,
   output logic        done,
   output logic [7:0]  resp,
   output logic        timeout,
   output logic        sclk,
   output logic        sclk_fall,
   output logic        spi_en,
   output logic [7:0]  spi_byte,
   input  logic [2:0]  spi_state,
   input  logic        miso,
   output logic        cs_n
);
   typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
   state_t      st;
   logic [7:0]  div, rx, ncr;
   logic [2:0]  bidx;
   logic [31:0] arg_q;
   logic [6:0]  crc_q;
   logic        tick, bnd, fin;
   logic [7:0]  nxt;
   assign tick = div == 8'(CLK_DIV - 1);
   assign bnd  = sclk_fall && spi_state == 3'd0;
   // byte following the one currently being shifted out
   assign nxt  = bidx == 3'd0 ? arg_q[31:24] :
                 bidx == 3'd1 ? arg_q[23:16] :
                 bidx == 3'd2 ? arg_q[15:8]  :
                 bidx == 3'd3 ? arg_q[7:0]   : {crc_q, 1'b1};
   assign fin  = st == RESP && bnd && (!rx[7] || ncr == 8'(NCR_MAX - 1));
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= IDLE;
         div       <= '0;
         rx        <= 8'hFF;
         ncr       <= '0;
         bidx      <= '0;
         arg_q     <= '0;
         crc_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         resp      <= 8'hFF;
         timeout   <= 1'b0;
         sclk      <= 1'b0;
         sclk_fall <= 1'b0;
         spi_en    <= 1'b0;
         spi_byte  <= 8'hFF;
         cs_n      <= 1'b1;
      end else begin
         sclk_fall <= 1'b0;
         done      <= 1'b0;
         case (st)
            IDLE: if (start) begin
               arg_q    <= cmd_arg;
               crc_q    <= crc7;
               spi_byte <= {2'b01, cmd_idx};
               bidx     <= '0;
               div      <= '0;
               st       <= CMD;
               cs_n     <= 1'b0;
               spi_en   <= 1'b1;
               busy     <= 1'b1;
            end
            CMD, RESP: begin
               div <= tick ? 8'd0 : div + 8'd1;
               if (tick) begin
                  sclk      <= ~sclk;
                  sclk_fall <= sclk;
                  if (!sclk) rx <= {rx[6:0], miso};
               end
               if (bnd && st == CMD) begin
                  bidx     <= bidx + 3'd1;
                  spi_byte <= bidx == 3'd5 ? 8'hFF : nxt;
                  if (bidx == 3'd5) begin
                     st  <= RESP;
                     ncr <= '0;
                  end
               end
               if (bnd && st == RESP && rx[7]) ncr <= ncr + 8'd1;
               // a valid response outranks the poll limit at the same boundary
               if (fin) begin
                  resp      <= rx[7] ? 8'hFF : rx;
                  timeout   <= rx[7];
                  st        <= DONE;
                  done      <= 1'b1;
                  spi_en    <= 1'b0;
                  cs_n      <= 1'b1;
                  spi_byte  <= 8'hFF;
                  sclk      <= 1'b0;
                  sclk_fall <= 1'b0;
                  div       <= '0;
               end
            end
            DONE: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: randomized bench with shifter/card models and a frame-level reference.
// Instance u[0] runs with CLK_DIV=2, u[1] with CLK_DIV=1.
module tb_spi_cmd_ctrl;
   localparam int NCR = 8;
   logic clk = 0, rst = 1;
   logic [5:0]  cmd_idx = 0;
   logic [31:0] cmd_arg = 0;
   logic [6:0]  crc7 = 0;
   logic [7:0]  rsp_bytes [0:15];
   logic [7:0]  exp_q [0:15];
   logic [7:0]  exp_resp;
   logic        exp_to;
   int          exp_n;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      logic start = 0, miso = 1, sclk_d = 0, cs_d = 1;
      logic busy, done, timeout, sclk, sclk_fall, spi_en, cs_n;
      logic [7:0] resp, spi_byte;
      logic [2:0] spi_state;
      logic [7:0] mosi_q [0:15];
      int n = 0, cyc = 0, last_rise = 0, period = 0, entry = 0, first_dly = 0, ndone = 0;
      spi_cmd_ctrl #(.CLK_DIV(g == 0 ? 2 : 1), .NCR_MAX(NCR)) dut (
         .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .crc7(crc7),
         .busy(busy), .done(done), .resp(resp), .timeout(timeout), .sclk(sclk),
         .sclk_fall(sclk_fall), .spi_en(spi_en), .spi_byte(spi_byte), .spi_state(spi_state),
         .miso(miso), .cs_n(cs_n));
      // byte shifter: bit index counts 7..0 on each falling sclk
      always @(posedge clk or negedge rst)
         if (!rst || !spi_en) spi_state <= 3'd7;
         else if (sclk_fall) spi_state <= spi_state - 3'd1;
      // card: records MOSI on each rise, presents the next response bit afterwards
      always @(posedge clk) begin
         #1;
         cyc++;
         if (!cs_n && cs_d) begin
            n = 0;
            entry = cyc;
         end
         if (sclk && !sclk_d && n < 128) begin
            if (n == 0) first_dly = cyc - entry;
            mosi_q[n/8][7-n%8] = spi_byte[spi_state];
            period = cyc - last_rise;
            last_rise = cyc;
            n++;
         end
         if (done) ndone++;
         sclk_d = sclk;
         cs_d = cs_n;
         miso = n < 48 ? 1'b1 : rsp_bytes[n/8-6][7-n%8];
      end
   end

   task automatic model;
      exp_q[0] = {2'b01, cmd_idx};
      exp_q[1] = cmd_arg[31:24];
      exp_q[2] = cmd_arg[23:16];
      exp_q[3] = cmd_arg[15:8];
      exp_q[4] = cmd_arg[7:0];
      exp_q[5] = {crc7, 1'b1};
      for (int j = 6; j < 16; j++) exp_q[j] = 8'hFF;
      exp_resp = 8'hFF;
      exp_to = 1'b1;
      exp_n = 6 + NCR;
      for (int j = 0; j < NCR; j++)
         if (!rsp_bytes[j][7]) begin
            exp_resp = rsp_bytes[j];
            exp_to = 1'b0;
            exp_n = 7 + j;
            break;
         end
   endtask

   function automatic int bad0();
      int b = 0;
      for (int j = 0; j < exp_n; j++) if (u[0].mosi_q[j] !== exp_q[j]) b++;
      return b;
   endfunction

   task automatic send(input logic [5:0] i, input logic [31:0] a, input logic [6:0] c, output bit ok);
      cmd_idx = i;
      cmd_arg = a;
      crc7 = c;
      model;
      @(negedge clk) u[0].start = 1;
      @(negedge clk) u[0].start = 0;
      ok = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (u[0].done) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2 rst = 0;
      #1;
      checks++;
      if ({u[0].busy, u[0].done, u[0].cs_n, u[0].spi_en, u[0].sclk, u[0].sclk_fall, u[0].timeout} !== 7'b0010000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0010000", {u[0].busy, u[0].done, u[0].cs_n, u[0].spi_en, u[0].sclk, u[0].sclk_fall, u[0].timeout});
      end
      checks++;
      if ({u[0].spi_byte, u[0].resp} !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_bytes: got %h want ffff", {u[0].spi_byte, u[0].resp});
      end
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      bit ok;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      rsp_bytes[1] = 8'h01;
      send(6'd0, 32'd0, 7'h4A, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_done: no done, want done"); end
      checks++;
      if (bad0() != 0) begin errors++; $display("FAIL basic_frame: %0d bad bytes, want 0", bad0()); end
      checks++;
      if ({u[0].mosi_q[0], u[0].mosi_q[5]} !== 16'h4095) begin
         errors++;
         $display("FAIL basic_literal: got %h want 4095", {u[0].mosi_q[0], u[0].mosi_q[5]});
      end
      checks++;
      if (u[0].n !== 64) begin errors++; $display("FAIL basic_bits: got %0d want 64", u[0].n); end
      checks++;
      if ({u[0].resp, u[0].timeout} !== 9'h002) begin
         errors++;
         $display("FAIL basic_resp: got %h/%b want 01/0", u[0].resp, u[0].timeout);
      end
      checks++;
      if (u[0].period !== 4 || u[0].first_dly !== 2) begin
         errors++;
         $display("FAIL basic_sclk: period %0d first %0d want 4 2", u[0].period, u[0].first_dly);
      end
      checks++;
      if ({u[0].busy, u[0].cs_n, u[0].spi_en, u[0].spi_byte} !== 11'b110_11111111) begin
         errors++;
         $display("FAIL done_state: got %b want 11011111111", {u[0].busy, u[0].cs_n, u[0].spi_en, u[0].spi_byte});
      end
      @(negedge clk);
      checks++;
      if ({u[0].done, u[0].busy} !== 2'b00) begin
         errors++;
         $display("FAIL done_pulse: got %b want 00", {u[0].done, u[0].busy});
      end
      repeat (10) @(negedge clk);
      checks++;
      if (u[0].resp !== 8'h01) begin errors++; $display("FAIL resp_hold: got %h want 01", u[0].resp); end
   endtask

   task automatic test_first_byte;
      bit ok;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      rsp_bytes[0] = 8'h00;
      send(6'd8, 32'h000001AA, 7'h43, ok);
      checks++;
      if (!ok || bad0() != 0 || u[0].n !== 56) begin
         errors++;
         $display("FAIL first_frame: ok %0d bad %0d bits %0d want 1 0 56", ok, bad0(), u[0].n);
      end
      checks++;
      if ({u[0].resp, u[0].timeout} !== 9'h000) begin
         errors++;
         $display("FAIL first_resp: got %h/%b want 00/0", u[0].resp, u[0].timeout);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      send(6'd55, 32'h12345678, 7'h11, ok);
      checks++;
      if (!ok || bad0() != 0 || u[0].n !== 112) begin
         errors++;
         $display("FAIL timeout_frame: ok %0d bad %0d bits %0d want 1 0 112", ok, bad0(), u[0].n);
      end
      checks++;
      if ({u[0].resp, u[0].timeout} !== 9'h1FF) begin
         errors++;
         $display("FAIL timeout_resp: got %h/%b want ff/1", u[0].resp, u[0].timeout);
      end
   endtask

   task automatic test_random;
      bit ok;
      for (int r = 0; r < 8; r++) begin
         int pos = $urandom_range(0, 9);
         for (int j = 0; j < 16; j++)
            rsp_bytes[j] = j < pos ? (8'h80 | 8'($urandom)) : j == pos ? (8'($urandom) & 8'h7F) : 8'hFF;
         send(6'($urandom), $urandom, 7'($urandom), ok);
         checks++;
         if (!ok || bad0() != 0 || u[0].n !== 8 * exp_n) begin
            errors++;
            $display("FAIL rand_frame[%0d]: ok %0d bad %0d bits %0d want 1 0 %0d", r, ok, bad0(), u[0].n, 8 * exp_n);
         end
         checks++;
         if ({u[0].resp, u[0].timeout} !== {exp_resp, exp_to}) begin
            errors++;
            $display("FAIL rand_resp[%0d]: got %h/%b want %h/%b", r, u[0].resp, u[0].timeout, exp_resp, exp_to);
         end
      end
   endtask

   task automatic test_start_ignored;
      int d0;
      bit ok = 0;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      rsp_bytes[2] = 8'h05;
      cmd_idx = 6'h11;
      cmd_arg = 32'hDEADBEEF;
      crc7 = 7'h2B;
      model;
      d0 = u[0].ndone;
      @(negedge clk) u[0].start = 1;
      @(negedge clk) u[0].start = 0;
      repeat (20) @(negedge clk);
      cmd_idx = 6'h3F;
      cmd_arg = 32'h0;
      crc7 = 7'h0;
      u[0].start = 1;
      @(negedge clk) u[0].start = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         ok = u[0].done;
      end
      repeat (40) @(negedge clk);
      checks++;
      if (u[0].ndone - d0 !== 1) begin errors++; $display("FAIL ign_dones: got %0d want 1", u[0].ndone - d0); end
      checks++;
      if (bad0() != 0 || u[0].resp !== 8'h05) begin
         errors++;
         $display("FAIL ign_frame: bad %0d resp %h want 0 05", bad0(), u[0].resp);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      bit ok;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      cmd_idx = 6'h2A;
      cmd_arg = $urandom;
      crc7 = 7'($urandom);
      d0 = u[0].ndone;
      @(negedge clk) u[0].start = 1;
      @(negedge clk) u[0].start = 0;
      for (int t = 0; t < 1000 && u[0].n < 28; t++) @(negedge clk);
      checks++;
      if (u[0].n < 28) begin errors++; $display("FAIL mid_reach: bits %0d want >=28", u[0].n); end
      #2 rst = 0;
      #1;
      checks++;
      if ({u[0].busy, u[0].done, u[0].cs_n, u[0].spi_en, u[0].sclk, u[0].sclk_fall, u[0].timeout} !== 7'b0010000) begin
         errors++;
         $display("FAIL mid_ctrl: got %b want 0010000", {u[0].busy, u[0].done, u[0].cs_n, u[0].spi_en, u[0].sclk, u[0].sclk_fall, u[0].timeout});
      end
      checks++;
      if ({u[0].spi_byte, u[0].resp, u[0].dut.rx} !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL mid_bytes: got %h want ffffff", {u[0].spi_byte, u[0].resp, u[0].dut.rx});
      end
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (20) @(negedge clk);
      checks++;
      if (u[0].ndone !== d0) begin errors++; $display("FAIL mid_nodone: got %0d want %0d", u[0].ndone - d0, 0); end
      rsp_bytes[3] = 8'h3C;
      send(6'($urandom), $urandom, 7'($urandom), ok);
      checks++;
      if (!ok || bad0() != 0 || u[0].resp !== 8'h3C) begin
         errors++;
         $display("FAIL mid_after: ok %0d bad %0d resp %h want 1 0 3c", ok, bad0(), u[0].resp);
      end
   endtask

   task automatic test_clk_div1;
      int b = 0;
      bit ok = 0;
      foreach (rsp_bytes[j]) rsp_bytes[j] = 8'hFF;
      rsp_bytes[1] = 8'h01;
      cmd_idx = 6'd0;
      cmd_arg = 32'd0;
      crc7 = 7'h4A;
      model;
      @(negedge clk) u[1].start = 1;
      @(negedge clk) u[1].start = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         ok = u[1].done;
      end
      for (int j = 0; j < exp_n; j++) if (u[1].mosi_q[j] !== exp_q[j]) b++;
      checks++;
      if (!ok || b != 0 || u[1].n !== 64) begin
         errors++;
         $display("FAIL div1_frame: ok %0d bad %0d bits %0d want 1 0 64", ok, b, u[1].n);
      end
      checks++;
      if (u[1].period !== 2 || u[1].first_dly !== 1) begin
         errors++;
         $display("FAIL div1_sclk: period %0d first %0d want 2 1", u[1].period, u[1].first_dly);
      end
      checks++;
      if ({u[1].resp, u[1].timeout} !== 9'h002) begin
         errors++;
         $display("FAIL div1_resp: got %h/%b want 01/0", u[1].resp, u[1].timeout);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_first_byte;
      test_timeout;
      test_random;
      test_start_ignored;
      test_reset_mid;
      test_clk_div1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk cycles (legal values 1 to 255).
REQ-002 The block SHALL have parameter NCR_MAX, default 8, giving the maximum number of response bytes polled before timeout (legal values 1 to 255).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  single-cycle request to send one command.
REQ-006 The block SHALL have port cmd_idx  input  6  SD command index.
REQ-007 The block SHALL have port cmd_arg  input  32  command argument.
REQ-008 The block SHALL have port crc7  input  7  precomputed command CRC.
REQ-009 The block SHALL have port busy  output  1  high while a transaction is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port resp  output  8  R1 response byte.
REQ-012 The block SHALL have port timeout  output  1  no response received within NCR_MAX bytes.
REQ-013 The block SHALL have port sclk  output  1  SPI clock to the card and to the byte shifter.
REQ-014 The block SHALL have port sclk_fall  output  1  one-cycle strobe, high in the cycle sclk goes from 1 to 0.
REQ-015 The block SHALL have port spi_en  output  1  byte shifter enable.
REQ-016 The block SHALL have port spi_byte  output  8  byte presented to the shifter.
REQ-017 The block SHALL have port spi_state  input  3  shifter bit index (7 down to 0, decremented on sclk_fall).
REQ-018 The block SHALL have port miso  input  1  card data out, already synchronised.
REQ-019 The block SHALL have port cs_n  output  1  card chip select, active low.

Function
REQ-020 The block SHALL implement the FSM states IDLE, CMD, RESP and DONE.
REQ-021 In IDLE, start=1 SHALL latch cmd_idx, cmd_arg and crc7, and then take the FSM to CMD on the next cycle with cs_n=0, spi_en=1, byte index=0 and busy=1.
REQ-022 start SHALL be ignored in every state other than IDLE, with no side effects.
REQ-023 SCLK SHALL run only in CMD and RESP: a divider counts 0 to CLK_DIV-1, toggles sclk on the terminal count and then wraps, giving an SCLK period of 2*CLK_DIV clk cycles.
REQ-024 sclk SHALL be held at 0 and the divider held at 0 in IDLE and DONE.
REQ-025 The first edge of sclk in a transaction SHALL be a rise, occurring CLK_DIV cycles after entry to CMD.
REQ-026 The CMD frame SHALL be sent MSB-first as six bytes: {2'b01,cmd_idx}, then cmd_arg[31:24], [23:16], [15:8], [7:0], then {crc7,1'b1}.
REQ-027 A byte boundary SHALL be defined as sclk_fall=1 with spi_state=0; at each boundary the byte index increments and spi_byte updates in the same cycle.
REQ-028 At the boundary ending byte 5, the FSM SHALL go to RESP, spi_byte SHALL become 8'hFF, and the response byte counter SHALL clear to 0.
REQ-029 A receive shift register SHALL shift in miso on every sclk rise (0 to 1) in CMD and RESP, as rx <= {rx[6:0],miso}.
REQ-030 At each RESP byte boundary, if rx[7]=0 then resp<=rx, timeout<=0 and the FSM goes to DONE.
REQ-031 At each RESP byte boundary with rx[7]=1, the response counter SHALL increment; if it reaches NCR_MAX, then resp<=8'hFF, timeout<=1 and the FSM goes to DONE.
REQ-032 If the valid-response condition and the NCR_MAX condition occur at the same boundary, the valid response SHALL take priority.
REQ-033 The DONE state SHALL last exactly one cycle with done=1, spi_en=0 and cs_n=1, then go to IDLE with busy=0.
REQ-034 busy SHALL be 1 in CMD, RESP and DONE, and 0 only in IDLE.
REQ-035 resp and timeout SHALL hold their value until the next DONE.
REQ-036 spi_byte SHALL be 8'hFF whenever spi_en=0.

Reset
REQ-037 rst=0 SHALL asynchronously force the FSM to IDLE with sclk=0, sclk_fall=0, spi_en=0, spi_byte=8'hFF, cs_n=1, busy=0, done=0, resp=8'hFF, timeout=0, all counters=0 and rx=8'hFF.
REQ-038 Reset asserted mid-transaction SHALL abort it with no done pulse.
REQ-039 After reset is released, the first start SHALL be accepted normally.

Verification
REQ-040 With CLK_DIV=2, start with cmd_idx=0, arg=0, crc7=7'h4A and the card responding 0x01 in the second response byte: MOSI SHALL carry 40 00 00 00 00 95 FF FF, then done=1, resp=0x01 and timeout=0, with an SCLK period of 4 clk cycles.
REQ-041 With the card responding 0x00 in the first response byte: exactly 7 bytes SHALL be clocked, then resp=0x00 and done=1.
REQ-042 With miso held at 1 and NCR_MAX=8: exactly 14 bytes SHALL be clocked, then resp=8'hFF, timeout=1 and done=1.
REQ-043 A start pulse during CMD SHALL cause no change to the frame or latched inputs, and exactly one done SHALL occur.
REQ-044 With rst=0 during byte 3: the REQ-037 values SHALL hold immediately and no done SHALL occur; a following start SHALL produce a full correct frame.
REQ-045 With CLK_DIV=1, the REQ-040 scenario SHALL show an SCLK period of 2 cycles and identical byte content.
